// File: rtl/argmax_layer.sv
// Purpose: sequential argmax over one vector of signed logits; reports winning class index and score.
// Latency: yumi_o same cycle as valid_i in IDLE; valid_o rises OUTPUT_SIZE cycles later (one compare/cycle).
// Backpressure: result held stable in DONE until ready_i; new vectors are refused (no yumi_o) until then.
module argmax_layer #(
    parameter int WORD_SIZE   = 16,
    parameter int OUTPUT_SIZE = 10,
    parameter int INDEX_WIDTH = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  valid_i,
    input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
    output logic                                  yumi_o,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [INDEX_WIDTH-1:0]                class_o,
    output logic [WORD_SIZE-1:0]                  score_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the last element; the compare at this index ends the scan.
    localparam logic [INDEX_WIDTH-1:0] LAST_K = INDEX_WIDTH'(OUTPUT_SIZE - 1);

    state_t                                r_state;
    state_t                                w_state_next;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] r_buf;
    logic [WORD_SIZE-1:0]                  r_best_val;
    logic [INDEX_WIDTH-1:0]                r_best_idx;
    logic [INDEX_WIDTH-1:0]                r_k;
    logic                                  r_valid;
    logic [INDEX_WIDTH-1:0]                r_class;
    logic [WORD_SIZE-1:0]                  r_score;

    logic [WORD_SIZE-1:0]                  w_cur;
    logic [WORD_SIZE-1:0]                  w_next_val;
    logic [INDEX_WIDTH-1:0]                w_next_idx;
    logic                                  w_capture;

    // State register; reset aborts any scan in progress.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the combinational consume strobe.
    always_comb begin
        w_state_next = r_state;
        yumi_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                yumi_o = valid_i & reset_i;
                if (valid_i) begin
                    w_state_next = (OUTPUT_SIZE > 1) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (r_k == LAST_K) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_valid && ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Select buf[k] for this cycle's compare.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (r_k == INDEX_WIDTH'(i)) begin
                w_cur = r_buf[i];
            end
        end
    end

    // Running best after this cycle's compare; strict greater keeps the lower index on ties.
    always_comb begin
        w_next_val = r_best_val;
        w_next_idx = r_best_idx;
        if ($signed(w_cur) > $signed(r_best_val)) begin
            w_next_val = w_cur;
            w_next_idx = r_k;
        end
    end

    assign w_capture = (r_state == S_IDLE) && valid_i;

    // Datapath: capture the vector, walk it one element per cycle, latch the result into output registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_buf      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_k        <= '0;
            r_valid    <= 1'b0;
            r_class    <= '0;
            r_score    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_buf      <= data_i;
                        r_best_val <= data_i[0];
                        r_best_idx <= '0;
                        r_k        <= INDEX_WIDTH'(1);
                        if (OUTPUT_SIZE == 1) begin
                            r_valid <= 1'b1;
                            r_class <= '0;
                            r_score <= data_i[0];
                        end
                    end
                end
                S_SCAN: begin
                    r_best_val <= w_next_val;
                    r_best_idx <= w_next_idx;
                    if (r_k == LAST_K) begin
                        r_valid <= 1'b1;
                        r_class <= w_next_idx;
                        r_score <= w_next_val;
                    end else begin
                        r_k <= r_k + INDEX_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign class_o = r_class;
    assign score_o = r_score;

endmodule

// File: tb/tb_argmax_layer.sv
// Bench for argmax_layer: directed and random vectors against a plain argmax reference.
// Covers reset values, latency, ties, signed extremes, backpressure, input stability, async reset, size 1.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_argmax_layer;

    localparam int N = 10;
    localparam int W = 16;
    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_i, ready_i, yumi, valid_o;
    vec_t        data_i;
    logic [3:0]  cls;
    logic [15:0] score;

    logic            valid1_i, ready1_i, yumi1, valid1_o;
    logic [0:0][15:0] data1;
    logic [0:0]      cls1;
    logic [15:0]     score1;

    int checks = 0;
    int errors = 0;

    argmax_layer #(.WORD_SIZE(W), .OUTPUT_SIZE(N)) dut (
        .clk_i(clk), .reset_i(rst_n), .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi),
        .valid_o(valid_o), .ready_i(ready_i), .class_o(cls), .score_o(score)
    );

    argmax_layer #(.WORD_SIZE(W), .OUTPUT_SIZE(1)) dut1 (
        .clk_i(clk), .reset_i(rst_n), .valid_i(valid1_i), .data_i(data1), .yumi_o(yumi1),
        .valid_o(valid1_o), .ready_i(ready1_i), .class_o(cls1), .score_o(score1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the largest signed value.
    function automatic int ref_idx(input vec_t v);
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(v[best])) best = i;
        end
        return best;
    endfunction

    function automatic vec_t rand_vec(input bit ties);
        vec_t v;
        logic [15:0] pool [4];
        pool[0] = 16'h8000; pool[1] = 16'h7FFF; pool[2] = 16'h0000; pool[3] = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            v[i] = ties ? pool[$urandom_range(3)] : 16'($urandom);
        end
        return v;
    endfunction

    // Present a vector in IDLE, scramble data_i afterwards, check latency and result against the model.
    task automatic do_vec(input vec_t v, input string tag, output logic [3:0] oc, output logic [15:0] os);
        int lat;
        int ei;
        ei = ref_idx(v);
        data_i  = v;
        valid_i = 1'b1;
        #1;
        check({tag, " yumi"}, 32'(yumi), 32'd1);
        lat = 0;
        while (lat < 40 && valid_o !== 1'b1) begin
            @(negedge clk);
            valid_i = 1'b0;
            data_i  = rand_vec(1'b0);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N));
        check({tag, " class"}, 32'(cls), 32'(ei));
        check({tag, " score"}, 32'(score), 32'(v[ei]));
        oc = cls;
        os = score;
        @(negedge clk);
        check({tag, " valid_low"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        vec_t v, vb;
        logic [3:0]  oc;
        logic [15:0] os;
        int lat, ei;

        rst_n = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = '0;
        valid1_i = 1'b1; ready1_i = 1'b1; data1 = '0;
        #12;
        check("rst valid_o", 32'(valid_o), 32'd0);
        check("rst class", 32'(cls), 32'd0);
        check("rst score", 32'(score), 32'd0);
        check("rst yumi", 32'(yumi), 32'd0);
        check("rst yumi1", 32'(yumi1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0; valid1_i = 1'b0;
        @(negedge clk);

        // Basic directed vector
        v = '0;
        v[0] = 16'h0100; v[1] = 16'hF000; v[2] = 16'h0400; v[3] = 16'h0200; v[9] = 16'h0300;
        do_vec(v, "basic", oc, os);
        check("basic class const", 32'(oc), 32'd2);
        check("basic score const", 32'(os), 32'h0400);

        // All-negative with most negative values
        for (int i = 0; i < N; i++) v[i] = 16'h8000;
        v[9] = 16'hFFFF;
        do_vec(v, "neg", oc, os);
        check("neg class const", 32'(oc), 32'd9);
        check("neg score const", 32'(os), 32'hFFFF);

        // Tie keeps lower index
        v = '0; v[3] = 16'h0500; v[7] = 16'h0500;
        do_vec(v, "tie", oc, os);
        check("tie class const", 32'(oc), 32'd3);

        // All equal -> class 0
        for (int i = 0; i < N; i++) v[i] = 16'h8000;
        do_vec(v, "equal", oc, os);
        check("equal class const", 32'(oc), 32'd0);

        // Random vectors, half drawn from a small pool to force ties
        for (int n = 0; n < 8; n++) begin
            do_vec(rand_vec(n[0]), "rand", oc, os);
        end

        // Backpressure: hold ready low for 20 cycles with a new vector offered
        v = rand_vec(1'b0);
        ei = ref_idx(v);
        ready_i = 1'b0;
        data_i = v; valid_i = 1'b1;
        #1;
        check("bp yumi", 32'(yumi), 32'd1);
        lat = 0;
        while (lat < 40 && valid_o !== 1'b1) begin
            @(negedge clk);
            valid_i = 1'b0;
            data_i = rand_vec(1'b0);
            lat++;
        end
        check("bp latency", 32'(lat), 32'(N));
        vb = rand_vec(1'b0);
        for (int i = 0; i < 20; i++) begin
            data_i = vb; valid_i = 1'b1;
            #1;
            check("bp hold yumi", 32'(yumi), 32'd0);
            check("bp hold valid", 32'(valid_o), 32'd1);
            check("bp hold class", 32'(cls), 32'(ei));
            check("bp hold score", 32'(score), 32'(v[ei]));
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        #1;
        check("bp after valid", 32'(valid_o), 32'd0);
        check("bp next yumi", 32'(yumi), 32'd1);
        do_vec(vb, "bp next", oc, os);

        // Async reset mid-scan; prior result registers are nonzero here
        v = rand_vec(1'b0);
        data_i = v; valid_i = 1'b1;
        #1;
        check("ar yumi", 32'(yumi), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        #2;
        rst_n = 1'b0; valid_i = 1'b1;
        #1;
        check("ar valid_o", 32'(valid_o), 32'd0);
        check("ar class", 32'(cls), 32'd0);
        check("ar score", 32'(score), 32'd0);
        check("ar yumi", 32'(yumi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        v = '0; v[0] = 16'h0010;
        do_vec(v, "post rst", oc, os);
        check("post rst class const", 32'(oc), 32'd0);
        check("post rst score const", 32'(os), 32'h0010);

        // Degenerate size 1
        data1[0] = 16'h1234; valid1_i = 1'b1;
        #1;
        check("n1 yumi", 32'(yumi1), 32'd1);
        check("n1 valid t", 32'(valid1_o), 32'd0);
        @(negedge clk);
        valid1_i = 1'b0; data1[0] = 16'hBEEF;
        check("n1 valid t+1", 32'(valid1_o), 32'd1);
        check("n1 class", 32'(cls1), 32'd0);
        check("n1 score", 32'(score1), 32'h1234);
        @(negedge clk);
        check("n1 valid low", 32'(valid1_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
